// File: rtl/mau_pkg.sv
// mau_pkg: bus encodings and FSM states shared by the
// memory access unit and its execute-stage clients.
package mau_pkg;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_NSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mau_state_t;

    function automatic logic [2:0] beat_step(input logic sz);
        return (sz == SIZE_WORD) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: read lane extraction and write byte
// replication keyed by transfer size and address lane.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic        size,
    input  logic [1:0]  lane,
    input  logic [31:0] bus_rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] bus_wdata
);

    always_comb begin
        load_data = bus_rdata;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0:    load_data = {24'b0, bus_rdata[7:0]};
                2'd1:    load_data = {24'b0, bus_rdata[15:8]};
                2'd2:    load_data = {24'b0, bus_rdata[23:16]};
                default: load_data = {24'b0, bus_rdata[31:24]};
            endcase
        end
    end

    assign bus_wdata = (size == SIZE_WORD) ? store_data
                                           : {4{store_data[7:0]}};

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: single-outstanding bus initiator for loads,
// stores and bursts; MAU_ALIGN_CHECK_EN rejects misaligned words.
module memory_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic              req_priv,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_len,
    input  logic [31:0]       beat_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_abort,
    output logic              resp_last,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    input  logic              data_valid,
    input  logic              abort,
    output logic              write,
    output logic              size,
    output logic [1:0]        prot,
    output logic [1:0]        trans
);

    mau_state_t state;
    mau_state_t state_next;

    logic [31:0] wsrc;
    logic [3:0]  len_q;
    logic [3:0]  beat_q;
    logic [7:0]  tcnt;
    logic        abort_q;

    logic        first;
    logic        last_beat;
    logic        expired;
    logic        done;
    logic        misaligned;
    logic [31:0] store_src;
    logic [31:0] load_data;

    assign first     = (beat_q == 4'd0);
    assign last_beat = (beat_q == len_q);
    assign expired   = (tcnt == 8'(TIMEOUT_CYCLES - 1));
    assign done      = abort_q || last_beat;

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned = (req_size == SIZE_WORD) &&
                        (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Later beats take store data live in their issue cycle,
    // then hold it in wsrc for the rest of the beat.
    assign store_src = (state == ISSUE && !first) ? beat_wdata : wsrc;

    mau_lane_align u_align (
        .size       (size),
        .lane       (addr[1:0]),
        .bus_rdata  (rdata),
        .store_data (store_src),
        .load_data  (load_data),
        .bus_wdata  (wdata)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        trans      = TRANS_IDLE;
        resp_valid = 1'b0;
        resp_abort = 1'b0;
        resp_last  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                trans      = first ? TRANS_NSEQ : TRANS_SEQ;
                state_next = WAIT;
            end
            WAIT: begin
                // data_valid and expiry together still complete normally
                if (data_valid || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_abort = abort_q;
                resp_last  = done;
                state_next = done ? IDLE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            write      <= 1'b0;
            size       <= 1'b0;
            prot       <= 2'b00;
            wsrc       <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            tcnt       <= '0;
            abort_q    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr    <= req_addr;
                        write   <= req_write;
                        size    <= req_size;
                        prot    <= {req_priv, 1'b1};
                        wsrc    <= req_wdata;
                        len_q   <= req_len;
                        beat_q  <= '0;
                        tcnt    <= '0;
                        abort_q <= misaligned;
                    end
                end
                ISSUE: begin
                    tcnt <= '0;
                    wsrc <= store_src;
                end
                WAIT: begin
                    tcnt <= tcnt + 8'd1;
                    if (data_valid) begin
                        abort_q    <= abort;
                        resp_rdata <= abort ? '0 : load_data;
                    end else if (expired) begin
                        abort_q    <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    if (!done) begin
                        addr   <= addr + ADDR_W'(beat_step(size));
                        beat_q <= beat_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Initiator side of the core's memory bus; the bus master that the word-addressed memory responder answers.
- Accepts single or burst (LDM/STM-style) load/store requests from the execute stage.
- Drives addr/wdata/write/size/prot/trans, waits for data_valid/abort, and returns lane-aligned read data with per-beat status.
- One beat outstanding at a time; includes a timeout so a dead responder cannot hang the pipeline.

Parameters:
- TIMEOUT_CYCLES, 15: max wait cycles after issue before a beat is forced to abort (1..255).
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when valid&ready
- req_write  in  1  1=store, 0=load
- req_size  in  1  1=word, 0=byte
- req_priv  in  1  privileged access, driven to prot[1]
- req_addr  in  32  start byte address
- req_wdata  in  32  store data for the first beat
- req_len  in  4  beats minus one (0..15 means 1..16 beats)
- beat_wdata  in  32  store data for beats 2..N, sampled at the issue cycle of each beat
- resp_valid  out  1  one-cycle pulse per completed beat
- resp_rdata  out  32  load data, lane-extracted, zero-extended for bytes
- resp_abort  out  1  beat aborted (bus abort or timeout)
- resp_last  out  1  final beat of the request (normal end or abort)
- addr  out  32  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data
- data_valid  in  1  responder completion
- abort  in  1  responder abort, qualified by data_valid
- write  out  1  bus direction
- size  out  1  bus size, 1=word
- prot  out  2  [0]=data(1)/opcode(0), always 1; [1]=req_priv
- trans  out  2  00 idle, 10 non-sequential, 11 sequential

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State is IDLE; timeout and beat counters are 0.
- States:
  - IDLE: req_ready=1. On valid&ready, latch the request and go to ISSUE.
  - ISSUE: lasts exactly one cycle. Drive trans (10 on the first beat, 11 on later beats), addr, write, size, wdata. Go to WAIT.
  - WAIT: trans=00 and bus outputs held. The timeout counter increments each cycle.
    - data_valid=1: the beat completes.
    - Counter reaches TIMEOUT_CYCLES: the beat completes with resp_abort=1.
  - RESP: lasts one cycle and pulses resp_valid.
    - If aborted or last beat: go to IDLE.
    - Otherwise: addr += 4 and go to ISSUE.
- Latency: a single word load with a zero-wait responder is accept → ISSUE (+1) → data_valid (+2) → resp_valid (+3). An N-beat burst takes 3N+1 cycles.
- Byte load: resp_rdata = {24'b0, rdata lane addr[1:0]}.
- Byte store: wdata = byte replicated on all four lanes.
- Word burst addresses advance by 4. Byte bursts advance by 1.
- Address wraps modulo 2^32 with no fault.
- Abort (abort&data_valid, or timeout): resp_abort=1, resp_last=1, remaining beats cancelled, no further trans.
- data_valid in IDLE or ISSUE: ignored.
- data_valid arriving on the same cycle the timeout expires: data_valid wins; the beat completes normally.
- Reset mid-burst: return to IDLE on the next edge, with trans=00 and resp_valid=0. Any late data_valid is ignored.
- req_ready is low from acceptance until the RESP cycle of the last beat has passed.

Optional Feature:
- MAU_ALIGN_CHECK_EN
  - Defined: a word request with req_addr[1:0]≠0 is not issued. The unit goes IDLE→RESP directly, with resp_valid=1, resp_abort=1, resp_last=1, and trans stays 00.
  - Undefined: addr is driven unmodified and the responder defines the result.

Decomposition:
- Shared package mau_pkg holds:
  - the trans encoding constants TRANS_IDLE=00 and TRANS_NSEQ=10 (also reused by execute), TRANS_SEQ=11
  - SIZE_BYTE/SIZE_WORD
  - the state enum {IDLE, ISSUE, WAIT, RESP}
- One natural sub-module: mau_lane_align, a combinational read lane extraction and write byte replication keyed by size and addr[1:0].

Test Plan:
- Word load @0x100, zero-wait responder returning 0xDEADBEEF → trans=10 for one cycle, resp_valid at cycle 3 with 0xDEADBEEF, resp_last=1, resp_abort=0.
- Byte store 0xA5 @0x203 → wdata=0xA5A5A5A5, size=0, write=1. Then byte load @0x203 with rdata=0xA5000000 → resp_rdata=0x000000A5.
- Word load burst of 4 beats (req_len=3) @0x10 → addrs 0x10/14/18/1C, trans 10,11,11,11, four resp_valid pulses, last on the fourth only, 13 cycles total.
- Burst of 4 with abort on beat 2 → two resp_valid pulses, the second with resp_abort=1 and resp_last=1. No third trans; req_ready=1 the following cycle.
- Responder never asserts data_valid, TIMEOUT_CYCLES=15 → resp_abort=1 exactly 15 WAIT cycles after issue. A data_valid on the expiry cycle instead gives a normal completion.
- rst asserted in WAIT of beat 2 → trans=00 and req_ready=1 after the edge, late data_valid produces no resp_valid. With MAU_ALIGN_CHECK_EN, a word load @0x102 gives an immediate resp_abort and trans never leaves 00.
